// File: rtl/flash_line_loader.sv
// SPI master that fetches one cache line from serial flash with a READ (0x03)
// command and hands it to the line buffer one little-endian 32-bit word at a time.
module flash_line_loader #(
  parameter int ADDRESS_WIDTH   = 24,
  parameter int WORDS_PER_LINE  = 4,
  parameter int SCK_HALF_PERIOD = 1,
  localparam int IDX_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] lineAddress,
  output logic                     busy,
  output logic                     done,
  output logic                     wordWriteEnable,
  output logic [IDX_W-1:0]         wordIndex,
  output logic [31:0]              wordData,
  output logic                     flash_csb,
  output logic                     flash_sck,
  output logic                     flash_mosi,
  input  logic                     flash_miso
);

  localparam int TX_W       = 8 + ADDRESS_WIDTH;
  localparam int TOTAL_BITS = TX_W + 32 * WORDS_PER_LINE;
  localparam int CNT_W      = $clog2(TOTAL_BITS);
  localparam int OFF_W      = $clog2(4 * WORDS_PER_LINE);
  localparam int HC_W       = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;

  localparam logic [7:0]               READ_CMD   = 8'h03;
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'((1 << OFF_W) - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    COMMAND,
    ADDRESS,
    DATA,
    DESELECT
  } state_t;

  state_t state, state_next;

  logic [HC_W-1:0]  half_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [4:0]       samp_cnt;
  logic [IDX_W-1:0] word_cnt;
  logic [TX_W-1:0]  tx_shift;
  logic [30:0]      rx_shift;
  logic             sck_q;
  logic             csb_q;

  logic        active;
  logic        half_done;
  logic        sck_rise;
  logic        sck_fall;
  logic        last_bit;
  logic [31:0] rx_word;

  // NOTE: every signal driven here gets a value before any branch, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    active     = (state == SELECT) || (state == COMMAND) ||
                 (state == ADDRESS) || (state == DATA);
    half_done  = (half_cnt == HC_W'(SCK_HALF_PERIOD - 1));
    // SELECT is the first low half of SCK, so the first rising edge ends it.
    sck_rise   = active && half_done && !sck_q;
    sck_fall   = active && half_done && sck_q;
    last_bit   = (bit_cnt == CNT_W'(TOTAL_BITS - 1));
    rx_word    = {rx_shift, flash_miso};
    state_next = state;

    case (state)
      IDLE:     if (start) state_next = SELECT;
      SELECT:   if (half_done) state_next = COMMAND;
      COMMAND:  if (sck_fall && bit_cnt == CNT_W'(7)) state_next = ADDRESS;
      ADDRESS:  if (sck_fall && bit_cnt == CNT_W'(TX_W - 1)) state_next = DATA;
      DATA:     if (sck_fall && last_bit) state_next = DESELECT;
      DESELECT: if (half_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_cnt        <= '0;
      bit_cnt         <= '0;
      samp_cnt        <= '0;
      word_cnt        <= '0;
      tx_shift        <= '0;
      rx_shift        <= '0;
      sck_q           <= 1'b0;
      csb_q           <= 1'b1;
      done            <= 1'b0;
      wordWriteEnable <= 1'b0;
      wordIndex       <= '0;
      wordData        <= '0;
    end else begin
      wordWriteEnable <= 1'b0;
      done            <= (state == DESELECT) && half_done;

      if (state == IDLE || half_done) half_cnt <= '0;
      else                            half_cnt <= half_cnt + HC_W'(1);

      if (state == IDLE && start) begin
        tx_shift <= {READ_CMD, lineAddress & ALIGN_MASK};
        bit_cnt  <= '0;
        samp_cnt <= '0;
        word_cnt <= '0;
        csb_q    <= 1'b0;
      end

      if (sck_rise) begin
        sck_q <= 1'b1;
        if (state == DATA) begin
          rx_shift <= rx_word[30:0];
          samp_cnt <= samp_cnt + 5'd1;
          if (samp_cnt == 5'd31) begin
            // First flash byte of the word lands in the least significant lane.
            wordWriteEnable <= 1'b1;
            wordData        <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
            wordIndex       <= word_cnt;
            word_cnt        <= word_cnt + IDX_W'(1);
          end
        end
      end

      if (sck_fall) begin
        sck_q    <= 1'b0;
        bit_cnt  <= bit_cnt + CNT_W'(1);
        tx_shift <= {tx_shift[TX_W-2:0], 1'b0};
        if (state == DATA && last_bit) csb_q <= 1'b1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign flash_csb  = csb_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = tx_shift[TX_W-1];

endmodule

// File: tb/tb_flash_line_loader.sv
// Directed bench for flash_line_loader: three builds (default, slow SCK,
// one-word line) each wired to a small behavioural READ-only SPI flash.
module tb_flash_line_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start, busy, done, wwe, csb, sck, mosi, miso;
  logic [23:0] addr [3];
  logic [31:0] wd   [3];
  logic [1:0]  wi0, wi1;
  logic        wi2;
  logic [1:0]  wi   [3];

  assign wi[0] = wi0;
  assign wi[1] = wi1;
  assign wi[2] = {1'b0, wi2};

  flash_line_loader #(.ADDRESS_WIDTH(24), .WORDS_PER_LINE(4), .SCK_HALF_PERIOD(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .lineAddress(addr[0]), .busy(busy[0]),
    .done(done[0]), .wordWriteEnable(wwe[0]), .wordIndex(wi0), .wordData(wd[0]),
    .flash_csb(csb[0]), .flash_sck(sck[0]), .flash_mosi(mosi[0]), .flash_miso(miso[0]));

  flash_line_loader #(.ADDRESS_WIDTH(24), .WORDS_PER_LINE(4), .SCK_HALF_PERIOD(3)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .lineAddress(addr[1]), .busy(busy[1]),
    .done(done[1]), .wordWriteEnable(wwe[1]), .wordIndex(wi1), .wordData(wd[1]),
    .flash_csb(csb[1]), .flash_sck(sck[1]), .flash_mosi(mosi[1]), .flash_miso(miso[1]));

  flash_line_loader #(.ADDRESS_WIDTH(24), .WORDS_PER_LINE(1), .SCK_HALF_PERIOD(1)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .lineAddress(addr[2]), .busy(busy[2]),
    .done(done[2]), .wordWriteEnable(wwe[2]), .wordIndex(wi2), .wordData(wd[2]),
    .flash_csb(csb[2]), .flash_sck(sck[2]), .flash_mosi(mosi[2]), .flash_miso(miso[2]));

  // Flash contents: 00..0F at 0x0, A5+i at 0x130+i, address^5A elsewhere.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a < 24'h10) return a[7:0];
    if (a >= 24'h130 && a < 24'h140) return 8'hA5 + 8'(a - 24'h130);
    return a[7:0] ^ 8'h5A;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_flash
    int          cnt = 0;
    logic [31:0] hdr = '0;
    logic        mb  = 1'b0;

    always @(posedge sck[g] or posedge csb[g]) begin
      if (csb[g]) cnt = 0;
      else begin
        if (cnt < 32) hdr = {hdr[30:0], mosi[g]};
        cnt++;
      end
    end

    always @(negedge sck[g]) begin
      int         b;
      logic [7:0] byt;
      if (!csb[g] && cnt >= 32) begin
        b   = cnt - 32;
        byt = flash_byte(hdr[23:0] + 24'(b / 8));
        mb  = byt[7 - (b % 8)];
      end
    end

    assign miso[g] = mb;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int          n_rise, n_strobe, n_done, mosi_bad, phase_bad, csb_to_done;
  int          post_strobe, post_done, extra;
  logic [31:0] tx_bits;
  logic [1:0]  s_idx  [8];
  logic [31:0] s_data [8];
  logic        first_busy, first_csb, done_busy, bb_busy, bb_csb, timed_out;
  logic        rst_csb, rst_sck, rst_busy, rst_wwe;

  // mode 0: plain load; 1: extra starts while busy; 2: reset after word 1;
  // 3: start again in the done cycle with address a_next.
  task automatic run_line(input int g, input logic [23:0] a, input int hp, input int mode,
                          input bit do_start, input logic [23:0] a_next);
    int   picks [5];
    int   phase_len, csb_rise_cyc;
    logic p_sck, p_mosi, p_csb;
    bit   finished;
    n_rise = 0; n_strobe = 0; n_done = 0; mosi_bad = 0; phase_bad = 0; csb_to_done = -1;
    post_strobe = 0; post_done = 0; extra = 0; tx_bits = '0; timed_out = 1'b0;
    first_busy = 1'b0; first_csb = 1'b1; done_busy = 1'b1; bb_busy = 1'b0; bb_csb = 1'b1;
    p_sck = 1'b0; p_mosi = 1'b0; p_csb = 1'b1; phase_len = 0; csb_rise_cyc = 0;
    finished = 1'b0;
    foreach (picks[i]) picks[i] = $urandom_range(5, 300);

    if (do_start) begin
      @(posedge clk); #1;
      addr[g]  = a;
      start[g] = 1'b1;
      @(posedge clk); #1;
      start[g] = 1'b0;
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (mode == 1) begin
        start[g] = 1'b0;
        foreach (picks[i]) if (cyc == picks[i]) start[g] = 1'b1;
      end
      if (cyc == 0) begin
        first_busy = busy[g];
        first_csb  = csb[g];
      end
      if (!csb[g] && sck[g] && !p_sck) begin
        n_rise++;
        if (n_rise <= 32) tx_bits = {tx_bits[30:0], mosi[g]};
      end
      if (mosi[g] !== p_mosi && !(p_sck && !sck[g])) mosi_bad++;
      if (!csb[g] && p_csb) phase_len = 1;
      else if (!p_csb) begin
        if (sck[g] !== p_sck) begin
          if (phase_len != hp) phase_bad++;
          phase_len = 1;
        end else phase_len++;
      end
      if (csb[g] && !p_csb) csb_rise_cyc = cyc;

      if (wwe[g]) begin
        if (n_strobe < 8) begin
          s_idx[n_strobe]  = wi[g];
          s_data[n_strobe] = wd[g];
        end
        n_strobe++;
        if (mode == 2 && wi[g] == 2'd1) begin
          rst = 1'b0;
          #1;
          rst_csb = csb[g]; rst_sck = sck[g]; rst_busy = busy[g]; rst_wwe = wwe[g];
          repeat (3) @(negedge clk);
          rst = 1'b1;
          for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (wwe[g])  post_strobe++;
            if (done[g]) post_done++;
            if (!csb[g]) extra++;
          end
          finished = 1'b1;
          break;
        end
      end

      if (done[g]) begin
        n_done++;
        csb_to_done = cyc - csb_rise_cyc;
        done_busy   = busy[g];
        finished    = 1'b1;
        if (mode == 1) begin
          start[g] = 1'b0;
          for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!csb[g] || done[g] || busy[g]) extra++;
          end
        end
        if (mode == 3) begin
          addr[g]  = a_next;
          start[g] = 1'b1;
          @(posedge clk); #1;
          start[g] = 1'b0;
          @(negedge clk);
          bb_busy = busy[g];
          bb_csb  = csb[g];
        end
        break;
      end
      p_sck = sck[g]; p_mosi = mosi[g]; p_csb = csb[g];
    end
    start[g] = 1'b0;
    if (!finished) timed_out = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    foreach (addr[i]) addr[i] = '0;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_wwe",  32'(wwe),  32'h0);
    check("reset_csb",  32'(csb),  32'h7);
    check("reset_sck",  32'(sck),  32'h0);
    check("reset_mosi", 32'(mosi), 32'h0);
    check("reset_data", wd[0], 32'h0);
    check("reset_idx",  32'(wi[0]), 32'h0);

    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic line at 0x000000.
    run_line(0, 24'h000000, 1, 0, 1'b1, 24'h0);
    check("l0_timeout", 32'(timed_out), 32'h0);
    check("l0_busy",    32'(first_busy), 32'h1);
    check("l0_csb",     32'(first_csb),  32'h0);
    check("l0_tx",      tx_bits, 32'h0300_0000);
    check("l0_rises",   n_rise, 160);
    check("l0_strobes", n_strobe, 4);
    for (int i = 0; i < 4; i++) check("l0_idx", 32'(s_idx[i]), i);
    check("l0_w0", s_data[0], 32'h0302_0100);
    check("l0_w1", s_data[1], 32'h0706_0504);
    check("l0_w2", s_data[2], 32'h0B0A_0908);
    check("l0_w3", s_data[3], 32'h0F0E_0D0C);
    check("l0_done",      n_done, 1);
    check("l0_done_busy", 32'(done_busy), 32'h0);
    check("l0_deselect",  csb_to_done, 1);
    check("l0_mosi_edge", mosi_bad, 0);

    // Address alignment.
    run_line(0, 24'h00013F, 1, 0, 1'b1, 24'h0);
    check("al_timeout", 32'(timed_out), 32'h0);
    check("al_tx",      tx_bits, 32'h0300_0130);
    check("al_w0",      s_data[0], 32'hA8A7_A6A5);
    check("al_w3",      s_data[3], 32'hB4B3_B2B1);
    check("al_strobes", n_strobe, 4);

    // Slow SCK build.
    run_line(1, 24'h000020, 3, 0, 1'b1, 24'h0);
    check("h3_timeout",   32'(timed_out), 32'h0);
    check("h3_phase",     phase_bad, 0);
    check("h3_mosi_edge", mosi_bad, 0);
    check("h3_deselect",  csb_to_done, 3);
    check("h3_rises",     n_rise, 160);
    check("h3_w0",        s_data[0], 32'h7978_7B7A);
    check("h3_idx3",      32'(s_idx[3]), 32'h3);

    // Starts while busy are dropped.
    run_line(0, 24'h000000, 1, 1, 1'b1, 24'h0);
    check("sf_timeout", 32'(timed_out), 32'h0);
    check("sf_done",    n_done, 1);
    check("sf_strobes", n_strobe, 4);
    check("sf_extra",   extra, 0);

    // Start in the done cycle is accepted.
    run_line(0, 24'h000000, 1, 3, 1'b1, 24'h000130);
    check("bb_timeout", 32'(timed_out), 32'h0);
    check("bb_done",    n_done, 1);
    check("bb_busy",    32'(bb_busy), 32'h1);
    check("bb_csb",     32'(bb_csb),  32'h0);
    run_line(0, 24'h0, 1, 0, 1'b0, 24'h0);
    check("bb2_timeout", 32'(timed_out), 32'h0);
    check("bb2_rises",   n_rise, 160);
    check("bb2_tx",      tx_bits, 32'h0300_0130);
    check("bb2_w0",      s_data[0], 32'hA8A7_A6A5);
    check("bb2_done",    n_done, 1);

    // Reset in the middle of DATA.
    run_line(0, 24'h000000, 1, 2, 1'b1, 24'h0);
    check("mr_timeout", 32'(timed_out), 32'h0);
    check("mr_strobes", n_strobe, 2);
    check("mr_csb",     32'(rst_csb),  32'h1);
    check("mr_sck",     32'(rst_sck),  32'h0);
    check("mr_busy",    32'(rst_busy), 32'h0);
    check("mr_wwe",     32'(rst_wwe),  32'h0);
    check("mr_post_strobe", post_strobe, 0);
    check("mr_post_done",   post_done, 0);
    check("mr_post_csb",    extra, 0);
    run_line(0, 24'h000000, 1, 0, 1'b1, 24'h0);
    check("mr2_timeout", 32'(timed_out), 32'h0);
    check("mr2_w2",      s_data[2], 32'h0B0A_0908);
    check("mr2_done",    n_done, 1);

    // One-word line build.
    run_line(2, 24'h000006, 1, 0, 1'b1, 24'h0);
    check("w1_timeout", 32'(timed_out), 32'h0);
    check("w1_tx",      tx_bits, 32'h0300_0004);
    check("w1_rises",   n_rise, 64);
    check("w1_strobes", n_strobe, 1);
    check("w1_idx",     32'(s_idx[0]), 32'h0);
    check("w1_w0",      s_data[0], 32'h0706_0504);
    check("w1_done",    n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flash_line_loader.md
Name: flash_line_loader

Overview:
- SPI master that fetches one cache line from the user SPI flash (standard READ 0x03, single-bit I/O) and writes it word-by-word into the flash cache line buffer.
- Sits between the flash cache controller (issues start/address, consumes word writes) and the user flash pins (CSB/SCK/IO0/IO1 on mprj_io[8:11]).

Parameters:
- ADDRESS_WIDTH, 24, flash byte address width.
- WORDS_PER_LINE, 4, 32-bit words per cache line; power of two, 1..64.
- SCK_HALF_PERIOD, 1, clk cycles per SCK half period; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active low (0 = reset).
- start  input  1  one-cycle request to load a line; ignored while busy=1.
- lineAddress  input  ADDRESS_WIDTH  byte address; latched on accepted start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the line is complete.
- wordWriteEnable  output  1  one-cycle strobe per received word.
- wordIndex  output  clog2(WORDS_PER_LINE) (min 1)  word slot being written.
- wordData  output  32  received word.
- flash_csb  output  1  chip select, active low.
- flash_sck  output  1  SPI clock, mode 0 (idle low).
- flash_mosi  output  1  to flash IO0.
- flash_miso  input  1  from flash IO1.

Behaviour:
- Reset values: busy=0, done=0, wordWriteEnable=0, wordIndex=0, wordData=0, flash_csb=1, flash_sck=0, flash_mosi=0.
- Reset mid-transfer: all outputs return to reset values immediately (async); no partial write or done is issued.
- Address alignment: latched address has low clog2(4*WORDS_PER_LINE) bits forced to 0.
- States: IDLE -> SELECT -> COMMAND -> ADDRESS -> DATA -> DESELECT -> IDLE.
- IDLE: csb=1, sck=0. start=1 moves to SELECT; busy=1 from the next cycle.
- SELECT: csb=0 for SCK_HALF_PERIOD cycles with sck=0; mosi already holds bit 7 of 0x03.
- SCK generation: half-period counter; sck toggles every SCK_HALF_PERIOD clk cycles while in COMMAND/ADDRESS/DATA.
- MOSI updates on each sck falling edge (the first bit is set up in SELECT). MISO is sampled in the clk cycle where sck goes 0->1.
- COMMAND: 8 SCK cycles, 0x03, MSB first.
- ADDRESS: ADDRESS_WIDTH SCK cycles, aligned address, MSB first. mosi=0 after the last address bit.
- DATA: 32*WORDS_PER_LINE SCK cycles. Each byte is received MSB first.
- Byte ordering is little-endian: the first flash byte of a word goes to wordData[7:0], the fourth byte to [31:24].
- Word write: wordWriteEnable pulses for 1 cycle, the clk cycle after the 32nd sample of each word. wordIndex counts 0..WORDS_PER_LINE-1. wordData is valid with the strobe and holds its value until the next strobe.
- After the last word's final rising edge, sck returns low after one half period, then the FSM enters DESELECT.
- DESELECT: csb=1 for SCK_HALF_PERIOD cycles, then done=1 for one cycle and busy=0 in the same cycle; return to IDLE.
- Back-to-back: start asserted in the done cycle is accepted (busy stays 1). Earlier starts are dropped.
- Total SCK cycles per line: 8+ADDRESS_WIDTH+32*WORDS_PER_LINE (160 at defaults).
- Address counter does not advance inside the block; flash sequential read handles line crossing. A line ending at 0xFFFFFF wraps per the flash model.

Test Plan:
- Pin sequence: reset, then start with lineAddress=0x000000 against a spiflash model loaded with bytes 00..0F. Required response:
  - 4 word strobes with indices 0..3 and data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C;
  - exactly 160 SCK rising edges while csb=0;
  - then one done pulse.
- Alignment: lineAddress=0x00013F with the model holding 0xA5+i at 0x130+i. Required response:
  - MOSI address bits = 0x000130;
  - word0 = 0xA8A7A6A5.
- Timing at SCK_HALF_PERIOD=3: each sck high/low phase is exactly 3 clk cycles; mosi only changes on sck falling edges; done arrives 3 cycles after csb rises.
- Start filtering: pulse start at 5 random cycles during busy -> no extra transfer, a single done. Then a start in the done cycle -> a second line load begins immediately with no idle cycle.
- Reset mid-DATA: deassert rst after word 1 is written -> csb=1, sck=0, busy=0 at once; no further strobes and no done. A subsequent start completes normally.
- WORDS_PER_LINE=1 build: a single strobe with index 0; 64 SCK cycles total.
